// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: default width, opcode constants, FSM states.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_REG    = 5'b01100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side request/response bundle of the ALU share arbiter.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*5-1:0]    req_opcode;
    logic [NUM_REQ*3-1:0]    req_func3;
    logic [NUM_REQ-1:0]      req_func7;
    logic [NUM_REQ*XLEN-1:0] req_op1;
    logic [NUM_REQ*XLEN-1:0] req_op2;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [XLEN-1:0]         rsp_data;
    logic [NUM_REQ-1:0]      rsp_ready;

    modport master (
        output req_valid, req_opcode, req_func3, req_func7, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_opcode, req_func3, req_func7, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational cyclic picker: first valid requester at or after rr_ptr.
// With ALU_ARB_FIXED_PRIO_EN the parent ties rr_ptr to 0, giving lowest-index priority.
module alu_rr_pick
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDXW-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    idx,
    output logic               any
);
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(rr_ptr) + k) % NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDXW'(j);
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, one op at a time (IDLE->ISSUE->RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = XLEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output logic [4:0]          alu_opcode,
    output logic [2:0]          alu_func3,
    output logic                alu_func7,
    output logic [XLEN-1:0]     alu_operand1,
    output logic [XLEN-1:0]     alu_operand2,
    input  logic [XLEN-1:0]     alu_result
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] pick_grant, grant;
    logic [IDXW-1:0]    pick_idx, rr_ptr;
    logic               pick_any, accept, rsp_done;
    logic [4:0]         sel_opcode;
    logic [2:0]         sel_func3;
    logic               sel_func7;
    logic [XLEN-1:0]    sel_op1, sel_op2, rsp_data_q;

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_opcode = '0;
        sel_func3  = '0;
        sel_func7  = 1'b0;
        sel_op1    = '0;
        sel_op2    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_opcode = bus.req_opcode[5*i +: 5];
                sel_func3  = bus.req_func3[3*i +: 3];
                sel_func7  = bus.req_func7[i];
                sel_op1    = bus.req_op1[XLEN*i +: XLEN];
                sel_op2    = bus.req_op2[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Handshake outputs are masked during reset so no accept or response is seen for a dropped op.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        rsp_done      = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: begin
                if (pick_any && !rst) begin
                    accept        = 1'b1;
                    bus.req_ready = pick_grant;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                if (!rst) begin
                    bus.rsp_valid = grant;
                    if (|(bus.rsp_ready & grant)) begin
                        rsp_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= '0;
            alu_opcode   <= '0;
            alu_func3    <= '0;
            alu_func7    <= 1'b0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            rsp_data_q   <= '0;
        end else begin
            if (accept) begin
                grant        <= pick_grant;
                alu_opcode   <= sel_opcode;
                alu_func3    <= sel_func3;
                alu_func7    <= sel_func7;
                alu_operand1 <= sel_op1;
                alu_operand2 <= sel_op2;
            end
            if (state == ISSUE) rsp_data_q <= alu_result;
        end
    end

    assign bus.rsp_data = rsp_data_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDXW-1:0] grant_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) grant_idx <= pick_idx;
            if (rsp_done) rr_ptr <= (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int W = 32;

    typedef struct packed {
        logic [4:0]   opc;
        logic [2:0]   f3;
        logic         f7;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(N), .XLEN(W)) bus ();

    logic [4:0]   alu_opcode;
    logic [2:0]   alu_func3;
    logic         alu_func7;
    logic [W-1:0] alu_operand1, alu_operand2, alu_result;

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_opcode   (alu_opcode),
        .alu_func3    (alu_func3),
        .alu_func7    (alu_func7),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result)
    );

    function automatic logic [W-1:0] alu_model(input op_t o);
        if (o.opc == OP_LUI) return o.b;
        case (o.f3)
            3'd0:    return o.f7 ? o.a - o.b : o.a + o.b;
            3'd1:    return o.a << o.b[4:0];
            3'd4:    return o.a ^ o.b;
            3'd6:    return o.a | o.b;
            3'd7:    return o.a & o.b;
            default: return o.a + o.b;
        endcase
    endfunction

    always_comb alu_result = alu_model({alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2});

    // Requester drive state and reference model state
    logic [N-1:0] v, rrdy;
    op_t          pay[N];
    bit           busy, hold_mode, rand_mode;
    int           age, g, ptr;
    op_t          last;
    logic [W-1:0] exp_data;
    int           grants[$];
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] vv, input int p);
        for (int k = 0; k < N; k++) if (vv[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        case ($urandom_range(0, 3))
            0:       o.opc = OP_IMM;
            1:       o.opc = OP_REG;
            2:       o.opc = OP_LUI;
            default: o.opc = 5'($urandom);
        endcase
        o.f3 = 3'($urandom);
        o.f7 = 1'($urandom);
        o.a  = $urandom;
        o.b  = $urandom;
        return o;
    endfunction

    task automatic drive();
        bus.req_valid = v;
        bus.rsp_ready = rrdy;
        for (int i = 0; i < N; i++) begin
            bus.req_opcode[5*i +: 5] = pay[i].opc;
            bus.req_func3[3*i +: 3]  = pay[i].f3;
            bus.req_func7[i]         = pay[i].f7;
            bus.req_op1[W*i +: W]    = pay[i].a;
            bus.req_op2[W*i +: W]    = pay[i].b;
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (!v[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    v[i]   = 1'b1;
                    pay[i] = rand_op();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                v[i] = 1'b0;
            end
        end
        rrdy = N'($urandom);
        rst  = ($urandom_range(0, 499) == 0);
    endtask

    // One clock: drive, check at negedge, advance the model at posedge.
    task automatic step();
        int w;
        logic [N-1:0] exp_rdy, exp_rv;
        drive();
        @(negedge clk);
        w = winner(v, ptr);
        if (!rst) begin
            exp_rdy = (!busy && w >= 0) ? (N'(1) << w) : '0;
            exp_rv  = (busy && age >= 2) ? (N'(1) << g) : '0;
            check("req_ready", bus.req_ready, exp_rdy);
            check("rsp_valid", bus.rsp_valid, exp_rv);
            check("alu_fields", {alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2}, last);
            if (busy && age >= 2) check("rsp_data", bus.rsp_data, exp_data);
        end
        @(posedge clk);
        if (rst) begin
            busy = 1'b0;
            ptr  = 0;
            last = '0;
        end else if (!busy && w >= 0) begin
            busy     = 1'b1;
            age      = 1;
            g        = w;
            last     = pay[w];
            exp_data = alu_model(pay[w]);
            grants.push_back(w);
            if (hold_mode) pay[w] = rand_op();
            else           v[w] = 1'b0;
        end else if (busy) begin
            if (age >= 2 && rrdy[g]) begin
                busy = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
                ptr = 0;
`else
                ptr = (g + 1) % N;
`endif
            end else if (age < 2) begin
                age++;
            end
        end
        #1;
        if (rand_mode) rand_inputs();
    endtask

    initial begin
        op_t p0;
        rst = 1'b1; v = '0; rrdy = '0;
        busy = 1'b0; hold_mode = 1'b0; rand_mode = 1'b0;
        age = 0; g = 0; ptr = 0; last = '0; exp_data = '0;
        for (int i = 0; i < N; i++) pay[i] = '0;
        repeat (2) step();
        rst = 1'b0;

        // Single ADDI 5+7
        pay[0] = '{opc: OP_IMM, f3: 3'd0, f7: 1'b0, a: 32'd5, b: 32'd7};
        v = 2'b01; rrdy = 2'b01;
        step();
        check("addi_op1", alu_operand1, 32'd5);
        check("addi_op2", alu_operand2, 32'd7);
        check("addi_opcode", alu_opcode, OP_IMM);
        repeat (2) step();
        check("addi_result", bus.rsp_data, 32'd12);
        step();

        // Reset held two cycles while in RESP
        pay[1] = rand_op(); v = 2'b10; rrdy = '0;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_alu_op1", alu_operand1, '0);
        check("rst_alu_opcode", alu_opcode, '0);

        // Contention from rr_ptr=0
        grants.delete();
        pay[0] = rand_op(); pay[1] = rand_op(); v = 2'b11; rrdy = 2'b11;
        repeat (6) step();
        pay[0] = rand_op(); pay[1] = rand_op(); v = 2'b11;
        repeat (1) step();
        check("contention_count", grants.size(), 3);
        if (grants.size() >= 3) begin
            check("contention_first", grants[0], 0);
            check("contention_second", grants[1], 1);
            check("contention_third", grants[2], 0);
        end
        v = '0;
        repeat (3) step();

        // Backpressure on requester 0
        grants.delete();
        p0 = rand_op(); pay[0] = p0; v = 2'b01; rrdy = '0;
        step();
        pay[1] = rand_op(); v[1] = 1'b1;
        repeat (6) step();
        check("bp_rsp_valid", bus.rsp_valid, 2'b01);
        check("bp_rsp_data", bus.rsp_data, alu_model(p0));
        check("bp_no_accept", grants.size(), 1);
        rrdy = 2'b01;
        repeat (2) step();
        check("bp_release_grant", grants.size() >= 2 ? grants[1] : -1, 1);
        rrdy = 2'b11;
        repeat (3) step();

        // Withdrawal during another requester's response
        grants.delete();
        pay[0] = rand_op(); v = 2'b01; rrdy = '0;
        repeat (2) step();
        pay[1] = rand_op(); v[1] = 1'b1;
        step();
        v[1] = 1'b0;
        step();
        rrdy = 2'b11;
        repeat (4) step();
        check("withdraw_grants", grants.size(), 1);

        // Both requesters valid continuously
        grants.delete();
        hold_mode = 1'b1;
        pay[0] = rand_op(); pay[1] = rand_op(); v = 2'b11; rrdy = 2'b11;
        repeat (12) step();
        hold_mode = 1'b0; v = '0;
        repeat (3) step();
        check("hold_count", grants.size(), 4);
        for (int k = 1; k < grants.size(); k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check("fixed_prio_grant", grants[k], 0);
`else
            check("rr_alternate", grants[k], 1 - grants[k-1]);
`endif
        end

        // Randomized traffic with occasional resets
        rand_mode = 1'b1;
        repeat (4000) step();
        rand_mode = 1'b0; rst = 1'b0; v = '0; rrdy = '1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
